// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : camera_pkg
//  Purpose  : Shared constants and types for the pixel readout path.
//  Revision : 1.0  initial release
// ============================================================================
package camera_pkg;

   localparam int DATA_W_DEF      = 8;   // bits per pixel sample
   localparam int COLS_DEF        = 2;   // pixels per row (one ADC per column)
   localparam int ROWS            = 2;   // nre1 = row 0, nre2 = row 1
   localparam int DROP_CNT_W      = 8;   // width of the saturating drop counter
   localparam int DARK_OFFSET_DEF = 16;  // default dark level

   // Read-side state machine encoding
   typedef enum logic [0:0] {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/readout_bank.sv
`default_nettype none
// ============================================================================
//  Module   : readout_bank
//  Purpose  : Single-frame store (ROWS x COLS samples). Whole rows are written
//             at once; pixels are read back by linear index row*COLS+col.
//             The full flag marks a complete frame awaiting readout.
//  Revision : 1.0  initial release
// ============================================================================
module readout_bank
   import camera_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int IDX_W  = $clog2(ROWS * COLS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en_i,
   input  logic                   wr_row_i,
   input  logic [COLS*DATA_W-1:0] wr_data_i,
   input  logic                   set_full_i,
   input  logic                   clr_full_i,
   input  logic [IDX_W-1:0]       rd_idx_i,
   output logic [DATA_W-1:0]      rd_data_o,
   output logic                   full_o
);

   logic [DATA_W-1:0] mem_q [ROWS*COLS];
   logic              full_q;

   // Row write and full-flag maintenance; clear wins over set
   always_ff @(posedge clk) begin
      if (reset) begin
         full_q <= 1'b0;
         for (int i = 0; i < ROWS * COLS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr_en_i) begin
            for (int c = 0; c < COLS; c++) begin
               mem_q[int'(wr_row_i) * COLS + c] <= wr_data_i[c*DATA_W +: DATA_W];
            end
         end
         if (clr_full_i) begin
            full_q <= 1'b0;
         end else if (set_full_i) begin
            full_q <= 1'b1;
         end
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];
   assign full_o    = full_q;

endmodule
`default_nettype wire

// File: rtl/pixel_readout_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_readout_buffer
//  Purpose  : Captures per-column ADC results of the 2-row pixel array,
//             stores complete frames in a ping-pong pair of banks and
//             streams pixels row-major over valid/ready.
//  Options  : DARK_SUB_EN - when defined, each sample is stored as
//             max(sample - DARK_OFFSET, 0); otherwise stored unmodified.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_readout_buffer
   import camera_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int COLS        = COLS_DEF,
   parameter int DARK_OFFSET = DARK_OFFSET_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   nre1,
   input  logic                   nre2,
   input  logic                   adc,
   input  logic                   erase,
   input  logic [COLS*DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   frame_drop,
   output logic                   seq_err,
   output logic [DROP_CNT_W-1:0]  drop_count
);

   localparam int               IDX_W    = $clog2(ROWS * COLS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS * COLS - 1);

   // ---------------------------------------------------------------------
   // Capture-side state
   // ---------------------------------------------------------------------
   logic                  adc_q, erase_q;
   logic                  exp_row_q, exp_row_d;
   logic                  wbank_q, wbank_d;
   logic                  seq_err_q, seq_err_d;
   logic                  frame_drop_q, frame_drop_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // ---------------------------------------------------------------------
   // Read-side state
   // ---------------------------------------------------------------------
   rd_state_e             state_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  rbank_q;
   logic [DATA_W-1:0]     out_data_q;
   logic                  out_valid_q;
   logic                  out_last_q;

   logic                  adc_rise, erase_rise;
   logic                  row0_sel, row1_sel;
   logic                  exp_row_eff;
   logic                  cap_wr_en, cap_wr_row, cap_set_full;
   logic                  rd_free;
   logic [IDX_W-1:0]      rd_idx;
   logic [COLS*DATA_W-1:0] cap_data;
   logic                  bank_full    [2];
   logic [DATA_W-1:0]     bank_rd_data [2];
   logic                  wbank_full, rbank_full;
   logic [DATA_W-1:0]     rd_data;

   assign adc_rise   = adc & ~adc_q;
   assign erase_rise = erase & ~erase_q;
   assign row0_sel   = ~nre1 &  nre2;
   assign row1_sel   =  nre1 & ~nre2;

   // An erase edge in the same cycle restarts the frame before the strobe is judged
   assign exp_row_eff = erase_rise ? 1'b0 : exp_row_q;

   assign wbank_full = bank_full[wbank_q];
   assign rbank_full = bank_full[rbank_q];
   assign rd_data    = bank_rd_data[rbank_q];

   // ---------------------------------------------------------------------
   // Optional dark-level subtraction, applied to the write data directly
   // ---------------------------------------------------------------------
`ifdef DARK_SUB_EN
   localparam logic [DATA_W-1:0] OFFSET_V = DATA_W'(DARK_OFFSET);

   for (genvar c = 0; c < COLS; c++) begin : g_dark
      logic [DATA_W-1:0] sample;
      assign sample = adc_data[c*DATA_W +: DATA_W];
      assign cap_data[c*DATA_W +: DATA_W] = (sample > OFFSET_V) ? (sample - OFFSET_V) : '0;
   end
`else
   assign cap_data = adc_data;
`endif

   // Capture decision for the current strobe edge
   always_comb begin
      exp_row_d    = exp_row_eff;
      wbank_d      = wbank_q;
      seq_err_d    = 1'b0;
      frame_drop_d = 1'b0;
      drop_cnt_d   = drop_cnt_q;
      cap_wr_en    = 1'b0;
      cap_wr_row   = 1'b0;
      cap_set_full = 1'b0;
      if (adc_rise) begin
         if (row0_sel) begin
            if (wbank_full) begin
               // No room: discard this frame; its row 1 will be rejected later
               frame_drop_d = 1'b1;
               exp_row_d    = 1'b0;
               if (drop_cnt_q != '1) begin
                  drop_cnt_d = drop_cnt_q + 1'b1;
               end
            end else begin
               cap_wr_en  = 1'b1;
               cap_wr_row = 1'b0;
               exp_row_d  = 1'b1;
               // A repeated row 0 is flagged but still replaces the old one
               seq_err_d  = exp_row_eff;
            end
         end else if (row1_sel) begin
            if (exp_row_eff) begin
               cap_wr_en    = 1'b1;
               cap_wr_row   = 1'b1;
               cap_set_full = 1'b1;
               wbank_d      = ~wbank_q;
               exp_row_d    = 1'b0;
            end else begin
               seq_err_d = 1'b1;
            end
         end else begin
            // Both or neither row enable asserted
            seq_err_d = 1'b1;
         end
      end
   end

   // Capture-side registers
   always_ff @(posedge clk) begin
      if (reset) begin
         adc_q        <= 1'b0;
         erase_q      <= 1'b0;
         exp_row_q    <= 1'b0;
         wbank_q      <= 1'b0;
         seq_err_q    <= 1'b0;
         frame_drop_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         adc_q        <= adc;
         erase_q      <= erase;
         exp_row_q    <= exp_row_d;
         wbank_q      <= wbank_d;
         seq_err_q    <= seq_err_d;
         frame_drop_q <= frame_drop_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Frame banks
   // ---------------------------------------------------------------------
   assign rd_free = out_valid_q & out_ready & out_last_q;
   assign rd_idx  = (state_q == RD_STREAM) ? (idx_q + 1'b1) : '0;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      readout_bank #(
         .DATA_W (DATA_W),
         .COLS   (COLS),
         .IDX_W  (IDX_W)
      ) u_bank (
         .clk        (clk),
         .reset      (reset),
         .wr_en_i    (cap_wr_en & (wbank_q == 1'(b))),
         .wr_row_i   (cap_wr_row),
         .wr_data_i  (cap_data),
         .set_full_i (cap_set_full & (wbank_q == 1'(b))),
         .clr_full_i (rd_free & (rbank_q == 1'(b))),
         .rd_idx_i   (rd_idx),
         .rd_data_o  (bank_rd_data[b]),
         .full_o     (bank_full[b])
      );
   end

   // Read FSM: presents the next pixel of bank R, advancing on each accepted beat
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RD_IDLE;
         idx_q       <= '0;
         rbank_q     <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            RD_IDLE: begin
               if (rbank_full) begin
                  state_q     <= RD_STREAM;
                  idx_q       <= '0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= rd_data;
                  out_last_q  <= (rd_idx == LAST_IDX);
               end
            end
            RD_STREAM: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     // Bank released; the other bank is picked up next cycle
                     state_q     <= RD_IDLE;
                     rbank_q     <= ~rbank_q;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end else begin
                     idx_q      <= rd_idx;
                     out_data_q <= rd_data;
                     out_last_q <= (rd_idx == LAST_IDX);
                  end
               end
            end
            default: begin
               state_q     <= RD_IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign frame_drop = frame_drop_q;
   assign seq_err    = seq_err_q;
   assign drop_count = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_readout_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_readout_buffer
//  Purpose  : Scoreboard bench for pixel_readout_buffer (COLS=2, DATA_W=8).
//             Optional build macro: DARK_SUB_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_readout_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        nre1 = 1'b1, nre2 = 1'b1, adc = 1'b0, erase = 1'b0;
   logic [15:0] adc_data = '0;
   logic [7:0]  out_data;
   logic        out_valid, out_ready = 1'b0, out_last;
   logic        frame_drop, seq_err;
   logic [7:0]  drop_count;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;

   always #5 clk = ~clk;

   pixel_readout_buffer #(.DATA_W(8), .COLS(2), .DARK_OFFSET(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .nre1       (nre1),
      .nre2       (nre2),
      .adc        (adc),
      .erase      (erase),
      .adc_data   (adc_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .frame_drop (frame_drop),
      .seq_err    (seq_err),
      .drop_count (drop_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] stored(input logic [7:0] s);
`ifdef DARK_SUB_EN
      return (s > 8'd16) ? s - 8'd16 : 8'd0;
`else
      return s;
`endif
   endfunction

   task automatic push_frame(input logic [15:0] r0, input logic [15:0] r1);
      sb.push_back('{d: stored(r0[7:0]),  l: 1'b0});
      sb.push_back('{d: stored(r0[15:8]), l: 1'b0});
      sb.push_back('{d: stored(r1[7:0]),  l: 1'b0});
      sb.push_back('{d: stored(r1[15:8]), l: 1'b1});
   endtask

   // One ADC strobe; checks the pulse flags in the cycle after the capture edge
   task automatic strobe(input logic n1, input logic n2, input logic [15:0] d,
                         input logic exp_seq, input logic exp_drop);
      @(posedge clk); #1;
      nre1 = n1; nre2 = n2; adc_data = d; adc = 1'b1;
      @(posedge clk); #1;
      adc = 1'b0; nre1 = 1'b1; nre2 = 1'b1;
      @(negedge clk);
      chk("seq_err", seq_err, exp_seq);
      chk("frame_drop", frame_drop, exp_drop);
   endtask

   task automatic erase_pulse();
      @(posedge clk); #1 erase = 1'b1;
      @(posedge clk); #1 erase = 1'b0;
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk); #1 out_ready = r;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      #1;
      chk(name, sb.size(), 0);
   endtask

   // Monitor: pops the scoreboard on every handshake, checks hold under stall
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", out_data, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("pix_data", out_data, e.d);
               chk("pix_last", out_last, e.l);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_drop", frame_drop, 0);
      chk("rst_seq", seq_err, 0);
      chk("rst_cnt", drop_count, 0);

      // Basic frame, checking valid latency and back-to-back beats
      set_ready(1'b1);
      erase_pulse();
      push_frame(16'h2211, 16'h4433);
      strobe(1'b0, 1'b1, 16'h2211, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 16'h4433, 1'b0, 1'b0);
      chk("valid_before", out_valid, 0);
      @(negedge clk);
      chk("valid_rise", out_valid, 1);
      chk("first_data", out_data, 8'h11);
      repeat (3) @(negedge clk);
      #1;
      chk("basic_back2back", sb.size(), 0);
      drain("basic_drain");

      // Backpressure
      set_ready(1'b0);
      push_frame(16'h2211, 16'h4433);
      strobe(1'b0, 1'b1, 16'h2211, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 16'h4433, 1'b0, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, 8'h11);
      end
      set_ready(1'b1);
      drain("bp_drain");

      // Overflow: third frame dropped, its row 1 rejected
      set_ready(1'b0);
      push_frame(16'h0201, 16'h0403);
      push_frame(16'h1211, 16'h1413);
      strobe(1'b0, 1'b1, 16'h0201, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 16'h0403, 1'b0, 1'b0);
      strobe(1'b0, 1'b1, 16'h1211, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 16'h1413, 1'b0, 1'b0);
      strobe(1'b0, 1'b1, 16'h2221, 1'b0, 1'b1);
      chk("ovf_cnt", drop_count, 1);
      strobe(1'b1, 1'b0, 16'h2423, 1'b1, 1'b0);
      set_ready(1'b1);
      drain("ovf_drain");

      // Sequence errors, erase, repeated row 0
      strobe(1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b0);
      strobe(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
      strobe(1'b0, 1'b1, 16'hCCBB, 1'b0, 1'b0);
      erase_pulse();
      strobe(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
      push_frame(16'h6655, 16'h8877);
      strobe(1'b0, 1'b1, 16'h6655, 1'b1, 1'b0);
      strobe(1'b1, 1'b0, 16'h8877, 1'b0, 1'b0);
      drain("seq_drain");

      // Reset mid-stream after two accepted beats
      set_ready(1'b0);
      sb.push_back('{d: stored(8'hA0), l: 1'b0});
      sb.push_back('{d: stored(8'hA1), l: 1'b0});
      strobe(1'b0, 1'b1, 16'hA1A0, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 16'hA3A2, 1'b0, 1'b0);
      set_ready(1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cnt", drop_count, 0);
      chk("mid_rst_beats", sb.size(), 0);
      set_ready(1'b1);
      push_frame(16'hB1B0, 16'hB3B2);
      strobe(1'b0, 1'b1, 16'hB1B0, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 16'hB3B2, 1'b0, 1'b0);
      drain("post_rst_drain");

      // Dark-level boundary values (expectation follows the build macro)
      push_frame(16'h200A, 16'h0530);
      strobe(1'b0, 1'b1, 16'h200A, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 16'h0530, 1'b0, 1'b0);
      drain("dark_drain");

      repeat (3) @(negedge clk);
      chk("final_idle", out_valid, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pixel_readout_buffer.md
Name: pixel_readout_buffer

Overview:
- Downstream of camera_control: captures the per-column ADC results of the 2-row pixel array during each readout phase, using nre1/nre2/adc/erase from camera_control.
- Stores complete frames in a 2-bank ping-pong buffer.
- Streams pixels row-major over a valid/ready interface to the host/display side.

Parameters:
- DATA_W, 8, bits per pixel sample.
- COLS, 2, pixels per row (one ADC channel per column); ROWS fixed at 2 (nre1 = row 0, nre2 = row 1).
- DARK_OFFSET, 16, dark level subtracted when DARK_SUB_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- nre1  in  1  row-0 read enable, active low.
- nre2  in  1  row-1 read enable, active low.
- adc  in  1  ADC conversion strobe; samples are captured on its rising edge.
- erase  in  1  frame-start marker; its rising edge aborts any partial frame.
- adc_data  in  COLS*DATA_W  column samples; column c is at bits [c*DATA_W +: DATA_W].
- out_data  out  DATA_W  pixel value.
- out_valid  out  1  pixel available.
- out_ready  in  1  consumer accepts.
- out_last  out  1  final pixel of the frame (index 2*COLS-1).
- frame_drop  out  1  one-cycle pulse when a frame is discarded.
- seq_err  out  1  one-cycle pulse on an illegal row strobe.
- drop_count  out  8  saturating count of dropped frames.

Behaviour:
- Reset (synchronous, active-high, one clock):
  - All outputs go to 0.
  - Both banks go empty; write bank W = 0, read bank R = 0; expected row = 0.
  - adc_q and erase_q are cleared.
  - Reset takes priority over everything, including a frame mid-stream: out_valid is 0 after the reset edge.
- Edge detection: registered adc_q and erase_q. adc_rise = adc & ~adc_q; erase_rise likewise.
- Capture, evaluated on an adc_rise edge:
  - nre1 = nre2 (both low or both high): seq_err pulse, no state change.
  - nre1 low, row 0:
    - If bank W is full (registered flag, checked before any same-cycle free): frame_drop pulse, drop_count += 1 (saturates at 255), frame ignored until the next row-0 strobe.
    - Otherwise: store the row in bank W; expected row becomes 1.
    - If row 0 arrives while row 1 is expected: seq_err pulse, and the new row 0 overwrites the old one.
  - nre2 low, row 1:
    - If row 1 is expected: store the row, mark bank W full, toggle W, expected row becomes 0.
    - Otherwise (including during a dropped frame): seq_err pulse, ignored.
- erase_rise: expected row returns to 0. Partial data is discarded; full banks are untouched.
- Read FSM, states IDLE and STREAM:
  - IDLE -> STREAM when bank R is full; index starts at 0. out_valid rises at the edge after the row-1 capture edge.
  - In STREAM:
    - out_valid = 1; out_data = bank[R][idx], where idx = row*COLS + col.
    - out_last = (idx == 2*COLS-1).
    - On valid & ready: idx increments.
    - On the last beat: bank R cleared, R toggles, state returns to IDLE. This gives one bubble cycle between frames.
  - While out_ready is low, out_data, out_valid and out_last hold stable.
- Capture and readout on different banks in the same cycle never conflict.

Optional Feature:
- Macro: DARK_SUB_EN.
- Defined: each sample is stored as max(sample − DARK_OFFSET, 0), computed at capture, with no added latency.
- Undefined: samples are stored unmodified and DARK_OFFSET is unused.

Decomposition:
- Package camera_pkg:
  - DATA_W and COLS defaults.
  - ROWS = 2.
  - Read FSM state encodings (IDLE, STREAM).
  - Drop-counter width (8).
- One sub-module, readout_bank: a single-frame store with row-write port, indexed read port, and full flag; instantiated twice.
- Top level holds edge detection, capture control, W/R pointers, read FSM and counters.

Test Plan (COLS = 2, DATA_W = 8):
- Basic frame: reset; erase pulse; adc strobe with nre1 = 0 and adc_data = 16'h2211; adc strobe with nre2 = 0 and adc_data = 16'h4433; out_ready = 1 -> out_data 11, 22, 33, 44 on consecutive cycles, out_last only on 44, out_valid rises one edge after the row-1 capture.
- Backpressure: as above with out_ready = 0 for 5 cycles -> out_valid = 1 and out_data = 8'h11 held; release -> all 4 beats delivered.
- Overflow: out_ready = 0; three frames captured -> frame_drop pulses at frame 3's row-0 strobe, drop_count = 1; then out_ready = 1 -> frame 1's 4 pixels, one bubble, then frame 2's 4 pixels.
- Sequence errors: adc strobe with nre1 = nre2 = 0 -> seq_err one cycle, no capture; row-1 strobe first -> seq_err; erase after row 0, then new rows 16'h6655 and 16'h8877 -> output 55, 66, 77, 88.
- Reset mid-stream: after 2 accepted beats, assert reset -> out_valid = 0, drop_count = 0; the next full frame streams from index 0.
- DARK_SUB_EN defined, DARK_OFFSET = 16: row 0 = 16'h200A -> output 00, 10.
